// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction and byte widths, instruction-memory
// limit, and the program-loader state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned IMEM_LIMIT = 32'h32;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_LEN_LO  = 3'd1,
    LD_LEN_HI  = 3'd2,
    LD_DATA_LO = 3'd3,
    LD_DATA_HI = 3'd4,
    LD_FLUSH   = 3'd5,
    LD_DONE    = 3'd6,
    LD_ERROR   = 3'd7
  } loader_state_e;

  // Header and payload states are the only ones that consume stream bytes.
  function automatic logic accepts_bytes(input loader_state_e st);
    return (st == LD_LEN_LO) || (st == LD_LEN_HI) ||
           (st == LD_DATA_LO) || (st == LD_DATA_HI);
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Length-prefixed byte-stream loader: packs bytes into little-endian 16-bit
// words at even addresses and holds the CPU in reset until the load finishes.
module instr_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_BYTES = IMEM_LIMIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [INSTR_W-1:0]  wr_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_hold,
  output logic [ADDR_W-1:0]   byte_count
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  loader_state_e       state_q, state_d;
  logic [BYTE_W-1:0]   len_lo_q, len_lo_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [BYTE_W-1:0]   lo_byte_q, lo_byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0]  wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   byte_count_q, byte_count_d;

  logic                accept;
  logic [15:0]         length_w;

  assign in_ready = accepts_bytes(state_q);
  assign accept   = in_valid && in_ready;
  assign length_w = {in_data, len_lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LD_IDLE;
      len_lo_q     <= '0;
      remaining_q  <= '0;
      lo_byte_q    <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      remaining_q  <= remaining_d;
      lo_byte_q    <= lo_byte_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      byte_count_q <= byte_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    remaining_d  = remaining_q;
    lo_byte_d    = lo_byte_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    byte_count_d = byte_count_q;

    unique case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) begin
          state_d      = LD_LEN_LO;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          byte_count_d = '0;
          addr_d       = '0;
        end
      end

      LD_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = LD_LEN_HI;
        end
      end

      LD_LEN_HI: begin
        if (accept) begin
          remaining_d = length_w;
          if (length_w > MAX_LEN) begin
            state_d = LD_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (length_w == 16'd0) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = LD_DATA_LO;
          end
        end
      end

      LD_DATA_LO: begin
        if (accept) begin
          lo_byte_d    = in_data;
          remaining_d  = remaining_q - 16'd1;
          byte_count_d = byte_count_q + ADDR_W'(1);
          // A lone trailing byte is padded with a zero high byte in FLUSH.
          state_d      = (remaining_q == 16'd1) ? LD_FLUSH : LD_DATA_HI;
        end
      end

      LD_DATA_HI: begin
        if (accept) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = addr_q;
          wr_data_d    = {in_data, lo_byte_q};
          addr_d       = addr_q + ADDR_W'(2);
          remaining_d  = remaining_q - 16'd1;
          byte_count_d = byte_count_q + ADDR_W'(1);
          if (remaining_q == 16'd1) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = LD_DATA_LO;
          end
        end
      end

      LD_FLUSH: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = {{BYTE_W{1'b0}}, lo_byte_q};
        addr_d    = addr_q + ADDR_W'(2);
        state_d   = LD_DONE;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end

      default: state_d = LD_IDLE;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign cpu_hold   = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader: header/payload sequences with
// hand-computed write addresses, data and status flags.
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;
  logic [15:0] byte_count;

  int vec_cnt;
  int err_cnt;

  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];

  instr_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe away from the rising edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL wait_not_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({in_ready, wr_en, busy, done, error, cpu_hold} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b required 000000",
               {in_ready, wr_en, busy, done, error, cpu_hold});
    end
    vec_cnt++;
    if (wr_addr !== 16'h0 || wr_data !== 16'h0 || byte_count !== 16'h0) begin
      err_cnt++;
      $display("FAIL reset_buses: addr=%h data=%h count=%h required 0",
               wr_addr, wr_data, byte_count);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_len4();
    clear_log();
    do_start();
    vec_cnt++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      err_cnt++;
      $display("FAIL len4_busy_rise: busy=%b hold=%b required 1 1", busy, cpu_hold);
    end
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'hA1);
    send_byte(8'hB2);
    vec_cnt++;
    if (wr_en !== 1'b1 || wr_addr !== 16'h0000 || wr_data !== 16'hB2A1) begin
      err_cnt++;
      $display("FAIL len4_word0: en=%b addr=%h data=%h required 1 0000 b2a1",
               wr_en, wr_addr, wr_data);
    end
    send_byte(8'hC3);
    vec_cnt++;
    if (busy !== 1'b1 || wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL len4_mid: busy=%b en=%b required 1 0", busy, wr_en);
    end
    send_byte(8'hD4);
    // Six rising edges after start: busy must already be low.
    vec_cnt++;
    if (busy !== 1'b0 || done !== 1'b1 || byte_count !== 16'd4 || in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL len4_end: busy=%b done=%b count=%0d rdy=%b required 0 1 4 0",
               busy, done, byte_count, in_ready);
    end
    tick();
    vec_cnt++;
    if (wq_addr.size() != 2) begin
      err_cnt++;
      $display("FAIL len4_nwrites: got %0d required 2", wq_addr.size());
    end else if (wq_addr[1] !== 16'h0002 || wq_data[1] !== 16'hD4C3) begin
      err_cnt++;
      $display("FAIL len4_word1: addr=%h data=%h required 0002 d4c3",
               wq_addr[1], wq_data[1]);
    end
  endtask

  task automatic test_flush();
    clear_log();
    do_start();
    vec_cnt++;
    if (done !== 1'b0 || byte_count !== 16'd0) begin
      err_cnt++;
      $display("FAIL flush_start_clear: done=%b count=%0d required 0 0", done, byte_count);
    end
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    vec_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || wr_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_state: rdy=%b busy=%b en=%b required 0 1 0",
               in_ready, busy, wr_en);
    end
    tick();
    vec_cnt++;
    if (wr_en !== 1'b1 || wr_addr !== 16'h0002 || wr_data !== 16'h0033 || done !== 1'b1) begin
      err_cnt++;
      $display("FAIL flush_write: en=%b addr=%h data=%h done=%b required 1 0002 0033 1",
               wr_en, wr_addr, wr_data, done);
    end
    tick();
    vec_cnt++;
    if (wq_addr.size() != 2) begin
      err_cnt++;
      $display("FAIL flush_nwrites: got %0d required 2", wq_addr.size());
    end else if (wq_addr[0] !== 16'h0000 || wq_data[0] !== 16'h2211) begin
      err_cnt++;
      $display("FAIL flush_word0: addr=%h data=%h required 0000 2211",
               wq_addr[0], wq_data[0]);
    end
  endtask

  task automatic test_error_and_zero();
    clear_log();
    do_start();
    send_byte(8'h33);
    send_byte(8'h00);
    vec_cnt++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL err_flags: err=%b busy=%b done=%b rdy=%b required 1 0 0 0",
               error, busy, done, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    in_valid = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b0 || error !== 1'b1 || wq_addr.size() != 0) begin
      err_cnt++;
      $display("FAIL err_hold: rdy=%b err=%b writes=%0d required 0 1 0",
               in_ready, error, wq_addr.size());
    end
    do_start();
    vec_cnt++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL err_clear: err=%b busy=%b required 0 1", error, busy);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    vec_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || byte_count !== 16'd0) begin
      err_cnt++;
      $display("FAIL zero_len: done=%b busy=%b count=%0d required 1 0 0",
               done, busy, byte_count);
    end
    tick();
    vec_cnt++;
    if (wq_addr.size() != 0) begin
      err_cnt++;
      $display("FAIL zero_len_writes: got %0d required 0", wq_addr.size());
    end
  endtask

  task automatic test_len50_gaps();
    int nbad;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp_d;
    clear_log();
    do_start();
    send_byte(8'h32);
    send_byte(8'h00);
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(8'(i + 1));
    end
    wait_not_busy();
    tick();
    vec_cnt++;
    if (done !== 1'b1 || byte_count !== 16'd50) begin
      err_cnt++;
      $display("FAIL len50_status: done=%b count=%0d required 1 50", done, byte_count);
    end
    vec_cnt++;
    if (wq_addr.size() != 25) begin
      err_cnt++;
      $display("FAIL len50_nwrites: got %0d required 25", wq_addr.size());
    end else begin
      nbad = 0;
      for (int k = 0; k < 25; k++) begin
        lo    = 8'(2 * k + 1);
        hi    = 8'(2 * k + 2);
        exp_d = {hi, lo};
        if (wq_addr[k] !== 16'(2 * k) || wq_data[k] !== exp_d) nbad++;
      end
      vec_cnt++;
      if (nbad != 0) begin
        err_cnt++;
        $display("FAIL len50_words: %0d bad words required 0", nbad);
      end
      vec_cnt++;
      if (wq_addr[24] !== 16'h0030 || wq_data[24] !== 16'h3231) begin
        err_cnt++;
        $display("FAIL len50_last: addr=%h data=%h required 0030 3231",
                 wq_addr[24], wq_data[24]);
      end
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    do_start();
    send_byte(8'h06);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({in_ready, wr_en, busy, done, error, cpu_hold} !== 6'b0 ||
        byte_count !== 16'h0 || wr_addr !== 16'h0 || wr_data !== 16'h0) begin
      err_cnt++;
      $display("FAIL midrst_outputs: flags=%b count=%h addr=%h data=%h required all 0",
               {in_ready, wr_en, busy, done, error, cpu_hold}, byte_count, wr_addr, wr_data);
    end
    vec_cnt++;
    if (wq_addr.size() != 1) begin
      err_cnt++;
      $display("FAIL midrst_nwrites: got %0d required 1", wq_addr.size());
    end else if (wq_addr[0] !== 16'h0000 || wq_data[0] !== 16'h0201) begin
      err_cnt++;
      $display("FAIL midrst_word: addr=%h data=%h required 0000 0201",
               wq_addr[0], wq_data[0]);
    end
    tick();
    rst = 1'b0;
    tick();
    clear_log();
    do_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick();
    vec_cnt++;
    if (wq_addr.size() != 1) begin
      err_cnt++;
      $display("FAIL midrst_reload_n: got %0d required 1", wq_addr.size());
    end else if (wq_addr[0] !== 16'h0000 || wq_data[0] !== 16'hBBAA || done !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_reload: addr=%h data=%h done=%b required 0000 bbaa 1",
               wq_addr[0], wq_data[0], done);
    end
  endtask

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    rst      = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    #2;
    test_reset();
    test_len4();
    test_flush();
    test_error_and_zero();
    test_len50_gaps();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
